// File: rtl/layer_compositor_pkg.sv
// Shared types, constants and window helpers for the N-layer video compositor.
package layer_compositor_pkg;

    localparam int unsigned PIX_W_DEF = 12;
    localparam int unsigned H_W_DEF   = 11;
    localparam int unsigned V_W_DEF   = 10;
    // Shadow window coordinates are zero-extended to this width; unsigned compares are unaffected.
    localparam int unsigned WIN_W     = 16;

    localparam logic [PIX_W_DEF-1:0] BLACK = 12'h000;

    typedef struct packed {
        logic [WIN_W-1:0] x0;
        logic [WIN_W-1:0] x1;
        logic [WIN_W-1:0] y0;
        logic [WIN_W-1:0] y1;
    } window_t;

    // x0/y0 inclusive, x1/y1 exclusive; x0 >= x1 or y0 >= y1 never matches.
    function automatic logic in_window(input window_t w, input logic [WIN_W-1:0] h,
                                       input logic [WIN_W-1:0] v);
        return (h >= w.x0) && (h < w.x1) && (v >= w.y0) && (v < w.y1);
    endfunction

    // Outermost one-pixel ring of a non-empty window.
    function automatic logic on_ring(input window_t w, input logic [WIN_W-1:0] h,
                                     input logic [WIN_W-1:0] v);
        return in_window(w, h, v) &&
               ((h == w.x0) || (h == w.x1 - WIN_W'(1)) ||
                (v == w.y0) || (v == w.y1 - WIN_W'(1)));
    endfunction

endpackage

// File: rtl/delay_line.sv
// Fixed-depth register delay with synchronous clear; DEPTH 0 is a plain wire.
module delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_out
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ok;
        assign unused_ok = clk_in ^ rst_in;
        assign q_out     = d_in;
    end else begin : g_regs
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d[0] = d_in;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    stage_q[i] <= '0;
                end
            end else begin
                stage_q <= stage_d;
            end
        end

        assign q_out = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/layer_compositor.sv
// N-layer compositor: delay-matches layers and VGA timing, applies frame-latched windows,
// colour-key and priority. Optional outline ring enabled by LAYER_COMPOSITOR_BORDER_EN.
module layer_compositor
    import layer_compositor_pkg::*;
#(
    parameter int unsigned             NUM_LAYERS = 2,
    parameter int unsigned             PIX_W      = PIX_W_DEF,
    parameter int unsigned             H_W        = H_W_DEF,
    parameter int unsigned             V_W        = V_W_DEF,
    parameter int unsigned             MAX_LAT    = 8,
    // Listed layer 0 first: the most significant byte is layer 0.
    parameter logic [NUM_LAYERS*8-1:0] LAYER_LAT  = {8'd2, 8'd8}
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [H_W-1:0]              hcount_in,
    input  logic [V_W-1:0]              vcount_in,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic                        blank_in,
    input  logic [NUM_LAYERS*PIX_W-1:0] layer_pix_in,
    input  logic [NUM_LAYERS-1:0]       layer_en_in,
    input  logic [NUM_LAYERS*H_W-1:0]   win_x0_in,
    input  logic [NUM_LAYERS*H_W-1:0]   win_x1_in,
    input  logic [NUM_LAYERS*V_W-1:0]   win_y0_in,
    input  logic [NUM_LAYERS*V_W-1:0]   win_y1_in,
    input  logic [NUM_LAYERS-1:0]       key_en_in,
    input  logic [PIX_W-1:0]            key_colour_in,
    input  logic [PIX_W-1:0]            bg_colour_in,
`ifdef LAYER_COMPOSITOR_BORDER_EN
    input  logic [PIX_W-1:0]            border_colour_in,
`endif
    output logic [PIX_W-1:0]            pixel_out,
    output logic                        hsync_out,
    output logic                        vsync_out,
    output logic                        blank_out
);

    localparam int unsigned TIM_W = H_W + V_W + 3;

    if (H_W > WIN_W || V_W > WIN_W) begin : g_bad_width
        $fatal(1, "layer_compositor: H_W/V_W wider than window coordinate width");
    end

    // Timing bundle carries active (not blank) so the cleared pipeline reads as blanked.
    logic [TIM_W-1:0] tim_in;
    logic [TIM_W-1:0] tim_dly;
    logic [H_W-1:0]   hd;
    logic [V_W-1:0]   vd;
    logic             hs_dly;
    logic             vs_dly;
    logic             active_dly;

    assign tim_in = {hsync_in, vsync_in, ~blank_in, vcount_in, hcount_in};
    assign {hs_dly, vs_dly, active_dly, vd, hd} = tim_dly;

    delay_line #(.WIDTH(TIM_W), .DEPTH(MAX_LAT)) u_tim_dly (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .d_in   (tim_in),
        .q_out  (tim_dly)
    );

    logic [PIX_W-1:0] lpix [NUM_LAYERS];

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
        localparam int unsigned LAT = 32'(LAYER_LAT[(NUM_LAYERS-1-i)*8 +: 8]);
        if (LAT > MAX_LAT) begin : g_bad_lat
            $fatal(1, "layer_compositor: LAYER_LAT entry exceeds MAX_LAT");
        end
        delay_line #(.WIDTH(PIX_W), .DEPTH((LAT > MAX_LAT) ? 0 : MAX_LAT - LAT)) u_pix_dly (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .d_in   (layer_pix_in[i*PIX_W +: PIX_W]),
            .q_out  (lpix[i])
        );
    end

    // Frame shadow registers, reloaded on the raw vsync rising edge.
    logic                  vs_prev_q, vs_prev_d;
    logic [NUM_LAYERS-1:0] en_q, en_d;
    logic [NUM_LAYERS-1:0] key_en_q, key_en_d;
    window_t               win_q [NUM_LAYERS];
    window_t               win_d [NUM_LAYERS];
    logic                  frame_edge;

    always_comb begin
        vs_prev_d  = vsync_in;
        frame_edge = vsync_in & ~vs_prev_q;
        en_d       = en_q;
        key_en_d   = key_en_q;
        win_d      = win_q;
        if (frame_edge) begin
            en_d     = layer_en_in;
            key_en_d = key_en_in;
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                win_d[i].x0 = WIN_W'(win_x0_in[i*H_W +: H_W]);
                win_d[i].x1 = WIN_W'(win_x1_in[i*H_W +: H_W]);
                win_d[i].y0 = WIN_W'(win_y0_in[i*V_W +: V_W]);
                win_d[i].y1 = WIN_W'(win_y1_in[i*V_W +: V_W]);
            end
        end
    end

    logic [WIN_W-1:0]      hd_w;
    logic [WIN_W-1:0]      vd_w;
    logic [NUM_LAYERS-1:0] hit;

    assign hd_w = WIN_W'(hd);
    assign vd_w = WIN_W'(vd);

    always_comb begin
        hit = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            hit[i] = en_q[i] && in_window(win_q[i], hd_w, vd_w) &&
                     !(key_en_q[i] && (lpix[i] == key_colour_in));
        end
    end

`ifdef LAYER_COMPOSITOR_BORDER_EN
    logic border_hit;

    always_comb begin
        border_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (en_q[i] && on_ring(win_q[i], hd_w, vd_w)) begin
                border_hit = 1'b1;
            end
        end
    end
`endif

    logic [PIX_W-1:0] pixel_q, pixel_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             blank_q, blank_d;

    // Walk from lowest priority up so the lowest-index hit is the last assignment.
    always_comb begin
        pixel_d = bg_colour_in;
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                pixel_d = lpix[i];
            end
        end
`ifdef LAYER_COMPOSITOR_BORDER_EN
        if (border_hit) begin
            pixel_d = border_colour_in;
        end
`endif
        if (!active_dly) begin
            pixel_d = PIX_W'(BLACK);
        end
        hsync_d = hs_dly;
        vsync_d = vs_dly;
        blank_d = ~active_dly;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vs_prev_q <= 1'b0;
            en_q      <= '0;
            key_en_q  <= '0;
            for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
                win_q[i] <= '0;
            end
            pixel_q   <= '0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            blank_q   <= 1'b1;
        end else begin
            vs_prev_q <= vs_prev_d;
            en_q      <= en_d;
            key_en_q  <= key_en_d;
            win_q     <= win_d;
            pixel_q   <= pixel_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            blank_q   <= blank_d;
        end
    end

    assign pixel_out = pixel_q;
    assign hsync_out = hsync_q;
    assign vsync_out = vsync_q;
    assign blank_out = blank_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Directed bench for layer_compositor: renderer models feed layers at their latencies.
module tb_layer_compositor;

    localparam int unsigned NL   = 2;
    localparam int unsigned PW   = 12;
    localparam int unsigned HW   = 11;
    localparam int unsigned VW   = 10;
    localparam int          LAT  = 9;
    localparam int          LAT0 = 2;
    localparam int          LAT1 = 8;

    typedef struct packed {
        logic          rst;
        logic [HW-1:0] h;
        logic [VW-1:0] v;
        logic          hs;
        logic          vs;
        logic          blank;
        logic [PW-1:0] p0;
        logic [PW-1:0] p1;
        logic [PW-1:0] exp;
    } vec_t;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [HW-1:0]     hcount_in;
    logic [VW-1:0]     vcount_in;
    logic              hsync_in, vsync_in, blank_in;
    logic [NL*PW-1:0]  layer_pix_in;
    logic [NL-1:0]     layer_en_in;
    logic [NL*HW-1:0]  win_x0_in, win_x1_in;
    logic [NL*VW-1:0]  win_y0_in, win_y1_in;
    logic [NL-1:0]     key_en_in;
    logic [PW-1:0]     key_colour_in, bg_colour_in;
`ifdef LAYER_COMPOSITOR_BORDER_EN
    logic [PW-1:0]     border_colour_in = 12'hFFF;
`endif
    logic [PW-1:0]     pixel_out;
    logic              hsync_out, vsync_out, blank_out;

    layer_compositor dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .hcount_in     (hcount_in),
        .vcount_in     (vcount_in),
        .hsync_in      (hsync_in),
        .vsync_in      (vsync_in),
        .blank_in      (blank_in),
        .layer_pix_in  (layer_pix_in),
        .layer_en_in   (layer_en_in),
        .win_x0_in     (win_x0_in),
        .win_x1_in     (win_x1_in),
        .win_y0_in     (win_y0_in),
        .win_y1_in     (win_y1_in),
        .key_en_in     (key_en_in),
        .key_colour_in (key_colour_in),
        .bg_colour_in  (bg_colour_in),
`ifdef LAYER_COMPOSITOR_BORDER_EN
        .border_colour_in (border_colour_in),
`endif
        .pixel_out     (pixel_out),
        .hsync_out     (hsync_out),
        .vsync_out     (vsync_out),
        .blank_out     (blank_out)
    );

    always #5 clk_in = ~clk_in;

    int   checks   = 0;
    int   failures = 0;
    int   step_n   = 0;
    vec_t log_q [16];

    function automatic vec_t mk(input int h, input int v, input bit hs, input bit vs,
                                input bit blank, input int p0, input int p1, input int e);
        vec_t r;
        r.rst   = 1'b0;
        r.h     = HW'(h);
        r.v     = VW'(v);
        r.hs    = hs;
        r.vs    = vs;
        r.blank = blank;
        r.p0    = PW'(p0);
        r.p1    = PW'(p1);
        r.exp   = PW'(e);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%h expected=%h", name, step_n, act, exp);
        end
    endtask

    // One pixel clock: check the output owed by the vector LAT steps back, then drive v.
    task automatic step(input vec_t v);
        vec_t o;
        @(posedge clk_in);
        #1;
        if (step_n >= LAT) o = log_q[(step_n - LAT) % 16];
        if (step_n < LAT || o.rst) begin
            chk("pixel_rst", int'(pixel_out), 0);
            chk("hsync_rst", int'(hsync_out), 0);
            chk("vsync_rst", int'(vsync_out), 0);
            chk("blank_rst", int'(blank_out), 1);
        end else begin
            chk("pixel", int'(pixel_out), int'(o.exp));
            chk("hsync", int'(hsync_out), int'(o.hs));
            chk("vsync", int'(vsync_out), int'(o.vs));
            chk("blank", int'(blank_out), int'(o.blank));
        end
        log_q[step_n % 16] = v;
        rst_in    = v.rst;
        hcount_in = v.h;
        vcount_in = v.v;
        hsync_in  = v.hs;
        vsync_in  = v.vs;
        blank_in  = v.blank;
        layer_pix_in[0  +: PW] = (step_n >= LAT0) ? log_q[(step_n - LAT0) % 16].p0 : '0;
        layer_pix_in[PW +: PW] = (step_n >= LAT1) ? log_q[(step_n - LAT1) % 16].p1 : '0;
        step_n++;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(mk(0, 0, 1'b0, 1'b0, 1'b1, 0, 0, 0));
    endtask

    task automatic vsync_latch();
        step(mk(0, 0, 1'b0, 1'b1, 1'b1, 0, 0, 0));
        step(mk(0, 0, 1'b0, 1'b1, 1'b1, 0, 0, 0));
        gap(10);
    endtask

    task automatic set_win(input int i, input int x0, input int x1, input int y0, input int y1);
        win_x0_in[i*HW +: HW] = HW'(x0);
        win_x1_in[i*HW +: HW] = HW'(x1);
        win_y0_in[i*VW +: VW] = VW'(y0);
        win_y1_in[i*VW +: VW] = VW'(y1);
    endtask

    vec_t split_tab [12];
    vec_t prio_tab  [5];
    vec_t nokey_tab [2];
    vec_t l1only_tab[2];

    initial begin
        #500000;
        $display("FAIL watchdog step=%0d", step_n);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t r;
        // layer0 red on right half, layer1 green on left half, bg black
        split_tab[0]  = mk(100,  100, 1, 0, 0, 12'hF00, 12'h0F0, 12'h0F0);
        split_tab[1]  = mk(600,  100, 0, 0, 0, 12'hF00, 12'h0F0, 12'hF00);
        split_tab[2]  = mk(600,  600, 1, 0, 0, 12'hF00, 12'h0F0, 12'h000);
        split_tab[3]  = mk(0,    0,   0, 0, 0, 12'hF00, 12'h0F0, 12'h0F0);
        split_tab[4]  = mk(511,  511, 1, 0, 0, 12'hF00, 12'h0F0, 12'h0F0);
        split_tab[5]  = mk(512,  0,   1, 0, 0, 12'hF00, 12'h0F0, 12'hF00);
        split_tab[6]  = mk(1023, 511, 0, 0, 0, 12'hF00, 12'h0F0, 12'hF00);
        split_tab[7]  = mk(512,  512, 0, 0, 0, 12'hF00, 12'h0F0, 12'h000);
        split_tab[8]  = mk(1024, 100, 1, 0, 0, 12'hF00, 12'h0F0, 12'h000);
        split_tab[9]  = mk(100,  100, 0, 1, 1, 12'hF00, 12'h0F0, 12'h000);
        split_tab[10] = mk(300,  700, 1, 0, 0, 12'hF00, 12'h0F0, 12'h000);
        split_tab[11] = mk(1500, 10,  0, 0, 0, 12'hF00, 12'h0F0, 12'h000);
        // full-width layer0 over layer1, layer0 keyed on F0F, bg blue
        prio_tab[0]   = mk(100,  100, 0, 0, 0, 12'hF0F, 12'h0F0, 12'h0F0);
        prio_tab[1]   = mk(600,  100, 1, 0, 0, 12'hF0F, 12'h0F0, 12'h00F);
        prio_tab[2]   = mk(100,  100, 0, 0, 0, 12'hF0E, 12'h0F0, 12'hF0E);
        prio_tab[3]   = mk(100,  600, 1, 0, 0, 12'hF00, 12'h0F0, 12'h00F);
        prio_tab[4]   = mk(1023, 511, 0, 0, 0, 12'hF0F, 12'h0F0, 12'h00F);
        nokey_tab[0]  = mk(100,  100, 0, 0, 0, 12'hF0F, 12'h0F0, 12'hF0F);
        nokey_tab[1]  = mk(600,  100, 1, 0, 0, 12'hF0F, 12'h0F0, 12'hF0F);
        l1only_tab[0] = mk(100,  100, 0, 0, 0, 12'hF00, 12'h0F0, 12'h0F0);
        l1only_tab[1] = mk(600,  100, 1, 0, 0, 12'hF00, 12'h0F0, 12'h00F);

        rst_in = 1'b1; hcount_in = '0; vcount_in = '0;
        hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b1;
        layer_pix_in = '0; layer_en_in = '0; key_en_in = '0;
        win_x0_in = '0; win_x1_in = '0; win_y0_in = '0; win_y1_in = '0;
        key_colour_in = 12'hF0F; bg_colour_in = 12'h000;

        // Reset held with timing toggling; outputs stay in reset state until flushed
        for (int i = 0; i < 3; i++) begin
            r = mk(i * 7 + 1, i * 3 + 1, i[0], ~i[0], i[0], 12'hABC, 12'h123, 0);
            r.rst = 1'b1;
            step(r);
        end
        gap(10);

        // Split screen
        layer_en_in = 2'b11; key_en_in = 2'b00;
        set_win(0, 512, 1024, 0, 512);
        set_win(1, 0,   512,  0, 512);
        vsync_latch();
        foreach (split_tab[i]) step(split_tab[i]);

        // Latency alignment: both renderers emit their hcount
        for (int h = 0; h < 1024; h++) step(mk(h, 20, h[4], 1'b0, 1'b0, h, h, h));
        gap(10);

        // Priority and colour key
        bg_colour_in = 12'h00F; key_en_in = 2'b01;
        set_win(0, 0, 1024, 0, 512);
        vsync_latch();
        foreach (prio_tab[i]) step(prio_tab[i]);
        gap(10);
        key_en_in = 2'b00;
        vsync_latch();
        foreach (nokey_tab[i]) step(nokey_tab[i]);
        gap(10);
        layer_en_in = 2'b10;
        vsync_latch();
        foreach (l1only_tab[i]) step(l1only_tab[i]);
        gap(10);

        // Frame latch: mid-frame window change is invisible until next vsync rise
        layer_en_in = 2'b11;
        set_win(0, 512, 1024, 0, 512);
        vsync_latch();
        step(mk(100, 200, 0, 0, 0, 12'hF00, 12'h0F0, 12'h0F0));
        set_win(1, 256, 512, 0, 512);
        step(mk(100, 200, 1, 0, 0, 12'hF00, 12'h0F0, 12'h0F0));
        step(mk(100, 300, 0, 0, 0, 12'hF00, 12'h0F0, 12'h0F0));
        step(mk(300, 300, 1, 0, 0, 12'hF00, 12'h0F0, 12'h0F0));
        step(mk(600, 300, 0, 0, 0, 12'hF00, 12'h0F0, 12'hF00));
        gap(10);
        vsync_latch();
        step(mk(100, 10, 0, 0, 0, 12'hF00, 12'h0F0, 12'h00F));
        step(mk(255, 10, 1, 0, 0, 12'hF00, 12'h0F0, 12'h00F));
        step(mk(256, 10, 0, 0, 0, 12'hF00, 12'h0F0, 12'h0F0));
        step(mk(511, 10, 1, 0, 0, 12'hF00, 12'h0F0, 12'h0F0));
        gap(10);

        // Vsync rise coinciding with reset is ignored; shadows stay cleared
        r = mk(0, 0, 1'b0, 1'b1, 1'b1, 0, 0, 0);
        r.rst = 1'b1;
        step(r);
        step(mk(100, 100, 0, 0, 0, 12'hF00, 12'h0F0, 12'h00F));
        step(mk(600, 100, 1, 0, 0, 12'hF00, 12'h0F0, 12'h00F));
        gap(LAT + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
